// File: rtl/fproc_arb_pkg.sv
// -----------------------------------------------------------------------------
// fproc_arb_pkg
// Shared definitions for the fproc arbiter slice.
//   - state_t        : arbiter FSM encoding (IDLE / REQ / RESP)
//   - DEF_* params   : default widths used by fproc_arbiter
// No ports (package).
// -----------------------------------------------------------------------------
package fproc_arb_pkg;

  localparam int DEF_N_CORES    = 4;
  localparam int DEF_ID_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for any pending request
    ST_REQ  = 2'd1,  // fproc_req held high until fproc_ack
    ST_RESP = 2'd2   // one-cycle core_ready to the granted core
  } state_t;

endpackage : fproc_arb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches the request vector
// starting at last_grant+1 (wrapping at N) and returns the first set bit.
// Written generically so it can front any shared resource.
//
// Ports:
//   pending    [N-1:0]          request vector
//   last_grant [$clog2(N)-1:0]  index served most recently
//   grant      [$clog2(N)-1:0]  chosen index (0 when valid=0)
//   valid                       at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] grant,
  output logic                 valid
);

  localparam int GW = $clog2(N);

  // Walk offsets from farthest to nearest so that the nearest set bit after
  // last_grant is the one that survives; avoids a priority break in the loop.
  // NOTE: every output of a combinational block is assigned a default before
  // any conditional write; a missed path would otherwise infer a latch.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = N; off >= 1; off--) begin
      int idx;
      idx = (int'(last_grant) + off) % N;
      if (pending[idx]) begin
        grant = GW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fproc_arbiter.sv
// -----------------------------------------------------------------------------
// fproc_arbiter
// Shares one function-processor (fproc) port between N_CORES core
// controllers. One-cycle request pulses are latched into a pending vector,
// granted round-robin one at a time, forwarded as a level req/ack handshake,
// and the result is returned with a one-cycle ready pulse to the granted
// core only.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   core_req     [N_CORES]           per-core request pulse
//   core_id      [N_CORES*ID_WIDTH]  per-core fproc ID, valid with core_req[i]
//   core_ready   [N_CORES]           per-core result-ready pulse
//   core_data    [DATA_WIDTH]        result data, held until the next response
//   fproc_req                        level request to the fproc
//   fproc_id     [ID_WIDTH]          ID of the granted request (0 when idle)
//   fproc_ack                        fproc result valid (only seen in REQ)
//   fproc_data   [DATA_WIDTH]        fproc result, valid with fproc_ack
//   grant_idx    [$clog2(N_CORES)]   current/last grant (debug)
//   err_overrun                      sticky: re-request while still pending
// -----------------------------------------------------------------------------
module fproc_arbiter
  import fproc_arb_pkg::*;
#(
  parameter int N_CORES    = DEF_N_CORES,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES*ID_WIDTH-1:0] core_id,
  output logic [N_CORES-1:0]          core_ready,
  output logic [DATA_WIDTH-1:0]       core_data,
  output logic                        fproc_req,
  output logic [ID_WIDTH-1:0]         fproc_id,
  input  logic                        fproc_ack,
  input  logic [DATA_WIDTH-1:0]       fproc_data,
  output logic [$clog2(N_CORES)-1:0]  grant_idx,
  output logic                        err_overrun
);

  localparam int GW = $clog2(N_CORES);

  state_t                state_q, state_d;
  logic [N_CORES-1:0]    pending_q;
  logic [ID_WIDTH-1:0]   id_q [N_CORES];
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         last_grant_q;
  logic [DATA_WIDTH-1:0] core_data_q;
  logic                  err_overrun_q;

  logic [GW-1:0]         arb_grant;
  logic                  arb_valid;
  logic                  load_grant;
  logic                  load_data;
  logic [N_CORES-1:0]    ready_vec;
  logic                  overrun_hit;

  rr_arbiter #(
    .N (N_CORES)
  ) u_rr_arbiter (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // ---------------------------------------------------------------------------
  // FSM: next state and Moore outputs. fproc_req and core_ready decode the
  // state register directly, so an asynchronous reset drops them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    load_data  = 1'b0;
    fproc_req  = 1'b0;
    ready_vec  = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          load_grant = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        fproc_req = 1'b1;
        if (fproc_ack) begin
          load_data = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_vec[grant_q] = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A request that hits an already-pending core is dropped and flagged,
  // unless that core is completing this very cycle, in which case the new
  // request simply takes the freed slot.
  assign overrun_hit = |(core_req & pending_q & ~ready_vec);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= '0;
      grant_q       <= '0;
      last_grant_q  <= GW'(N_CORES - 1);  // core 0 gets first priority
      core_data_q   <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      // Set wins over clear for the same core.
      pending_q <= (pending_q & ~ready_vec) | core_req;
      if (overrun_hit) err_overrun_q <= 1'b1;
      if (load_grant)  grant_q       <= arb_grant;
      if (|ready_vec)  last_grant_q  <= grant_q;
      if (load_data)   core_data_q   <= fproc_data;
    end
  end

  // NOTE: the ID store is deliberately left without reset; an entry is only
  // ever read through a set pending bit, and pending itself is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (core_req[i] && (!pending_q[i] || ready_vec[i])) begin
        id_q[i] <= core_id[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  assign fproc_id    = fproc_req ? id_q[grant_q] : '0;
  assign core_ready  = ready_vec;
  assign core_data   = core_data_q;
  assign grant_idx   = grant_q;
  assign err_overrun = err_overrun_q;

endmodule : fproc_arbiter
